// File: rtl/intra4_nbr_buffer.sv
// intra4_nbr_buffer
//   Neighbour-edge buffer for the 4x4 intra predictors. It walks the 4x4
//   blocks of a picture in raster order. For each block it first offers the
//   top row and left column (PRED). It then takes the block's reconstruction
//   (REC) and keeps the bottom row in a line buffer and the right column as
//   the next block's left edge.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
//   both high. A valid, once raised, holds its payload stable until that edge.
//   nb_valid and rec_ready are never high together.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   start               begin a picture (ignored while busy)
//   blk_cols, blk_rows  picture size in 4x4 blocks, sampled on start
//   busy, done          picture in progress / one-cycle completion pulse
//   nb_valid, nb_ready  neighbour handshake (top, left, nb_x, nb_y)
//   rec_valid, rec_ready, rec_data  reconstructed block handshake
//
// FSM state is held in 'state' (type state_t) for observation.
module intra4_nbr_buffer #(
  parameter int BIT_WIDTH    = 8,
  parameter int BLOCK_SIZE   = 4,
  parameter int MAX_BLK_COLS = 64,
  parameter int COL_W        = 6,
  parameter int TOP_DEFAULT  = 127,
  parameter int LEFT_DEFAULT = 129
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    start,
  input  logic [COL_W:0]                          blk_cols,
  input  logic [COL_W:0]                          blk_rows,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    nb_valid,
  input  logic                                    nb_ready,
  output logic [BIT_WIDTH*BLOCK_SIZE-1:0]         top,
  output logic [BIT_WIDTH*BLOCK_SIZE-1:0]         left,
  output logic [COL_W-1:0]                        nb_x,
  output logic [COL_W-1:0]                        nb_y,
  input  logic                                    rec_valid,
  output logic                                    rec_ready,
  input  logic [BIT_WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0] rec_data
);

  localparam int EDGE_W = BIT_WIDTH * BLOCK_SIZE;
  localparam int BLK_W  = EDGE_W * BLOCK_SIZE;
  localparam logic [BIT_WIDTH-1:0] TOP_PIX  = BIT_WIDTH'(TOP_DEFAULT);
  localparam logic [BIT_WIDTH-1:0] LEFT_PIX = BIT_WIDTH'(LEFT_DEFAULT);
  localparam logic [EDGE_W-1:0] TOP_EDGE  = {BLOCK_SIZE{TOP_PIX}};
  localparam logic [EDGE_W-1:0] LEFT_EDGE = {BLOCK_SIZE{LEFT_PIX}};
  localparam logic [COL_W:0] ONE_D = (COL_W+1)'(1);
  localparam logic [COL_W-1:0] ONE_X = COL_W'(1);

  typedef enum logic [1:0] {IDLE, PRED, REC, DONE} state_t;

  state_t            state;
  logic [COL_W:0]    cols_q;
  logic [COL_W:0]    rows_q;
  logic [COL_W-1:0]  x;
  logic [COL_W-1:0]  y;
  logic [EDGE_W-1:0] line_buf [MAX_BLK_COLS];

  logic              nb_fire;
  logic              rec_fire;
  logic              last_col;
  logic              last_row;
  logic [COL_W-1:0]  nx;
  logic [COL_W-1:0]  ny;
  logic [EDGE_W-1:0] rec_row3;
  logic [EDGE_W-1:0] rec_col3;
  logic [EDGE_W-1:0] next_top;

  assign nb_fire  = nb_valid & nb_ready;
  assign rec_fire = rec_valid & rec_ready;
  assign last_col = ({1'b0, x} == (cols_q - ONE_D));
  assign last_row = ({1'b0, y} == (rows_q - ONE_D));
  assign nx       = last_col ? '0 : x + ONE_X;
  assign ny       = last_col ? y + ONE_X : y;
  assign rec_row3 = rec_data[BLK_W-1 -: EDGE_W];

  always_comb begin
    rec_col3 = '0;
    for (int r = 0; r < BLOCK_SIZE; r++) begin
      rec_col3[r*BIT_WIDTH +: BIT_WIDTH] =
        rec_data[(r*BLOCK_SIZE + BLOCK_SIZE - 1)*BIT_WIDTH +: BIT_WIDTH];
    end
  end

  // The neighbour registers load on the same edge that writes line_buf[x].
  // In a one-column picture the next block reads that same entry, so the
  // incoming bottom row is forwarded instead of the stale stored row.
  always_comb begin
    if (ny == '0)
      next_top = TOP_EDGE;
    else if (nx == x)
      next_top = rec_row3;
    else
      next_top = line_buf[nx];
  end

  // Line buffer needs no reset: row 0 never reads it.
  always_ff @(posedge clk) begin
    if (rec_fire)
      line_buf[x] <= rec_row3;
  end

  // The 'left' output register also stores the left edge carried between
  // horizontally adjacent blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      nb_valid  <= 1'b0;
      rec_ready <= 1'b0;
      top       <= '0;
      left      <= '0;
      nb_x      <= '0;
      nb_y      <= '0;
      cols_q    <= '0;
      rows_q    <= '0;
      x         <= '0;
      y         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (done) begin
            // Trailing cycle of the done pulse: busy drops after it.
            busy <= 1'b0;
          end else if (start) begin
            busy   <= 1'b1;
            cols_q <= blk_cols;
            rows_q <= blk_rows;
            x      <= '0;
            y      <= '0;
            if (blk_cols == '0 || blk_rows == '0) begin
              state <= DONE;
            end else begin
              state    <= PRED;
              nb_valid <= 1'b1;
              top      <= TOP_EDGE;
              left     <= LEFT_EDGE;
              nb_x     <= '0;
              nb_y     <= '0;
            end
          end
        end
        PRED: begin
          if (nb_fire) begin
            nb_valid  <= 1'b0;
            rec_ready <= 1'b1;
            state     <= REC;
          end
        end
        REC: begin
          if (rec_fire) begin
            rec_ready <= 1'b0;
            x         <= nx;
            y         <= ny;
            if (last_col && last_row) begin
              state <= DONE;
            end else begin
              state    <= PRED;
              nb_valid <= 1'b1;
              top      <= next_top;
              left     <= (nx == '0) ? LEFT_EDGE : rec_col3;
              nb_x     <= nx;
              nb_y     <= ny;
            end
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_intra4_nbr_buffer.sv
// tb_intra4_nbr_buffer
//   Bench for intra4_nbr_buffer. Expected neighbours for each block are
//   built from a pixel formula and queued before a picture starts. They are
//   popped and compared as the DUT presents each block.
module tb_intra4_nbr_buffer;

  localparam int COL_W = 6;
  localparam int NB_W  = 2*COL_W + 64;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [COL_W:0] blk_cols;
  logic [COL_W:0] blk_rows;
  logic         busy;
  logic         done;
  logic         nb_valid;
  logic         nb_ready;
  logic [31:0]  top;
  logic [31:0]  left;
  logic [COL_W-1:0] nb_x;
  logic [COL_W-1:0] nb_y;
  logic         rec_valid;
  logic         rec_ready;
  logic [127:0] rec_data;

  logic [NB_W-1:0] exp_q[$];
  int tests_run    = 0;
  int tests_failed = 0;
  int done_cnt     = 0;

  intra4_nbr_buffer dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .blk_cols(blk_cols), .blk_rows(blk_rows),
    .busy(busy), .done(done),
    .nb_valid(nb_valid), .nb_ready(nb_ready),
    .top(top), .left(left), .nb_x(nb_x), .nb_y(nb_y),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_data(rec_data)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] pix(input int bx, input int by, input int cols,
                                     input int seed, input int r, input int c);
    int blk;
    blk = by*cols + bx;
    return 8'(16*blk + 4*r + c + seed + (blk >> 4)*5);
  endfunction

  function automatic logic [127:0] model_blk(input int bx, input int by, input int cols, input int seed);
    logic [127:0] d;
    d = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        d[(r*4+c)*8 +: 8] = pix(bx, by, cols, seed, r, c);
    return d;
  endfunction

  function automatic logic [NB_W-1:0] model_nb(input int bx, input int by, input int cols, input int seed);
    logic [31:0] t;
    logic [31:0] l;
    for (int c = 0; c < 4; c++)
      t[c*8 +: 8] = (by == 0) ? 8'h7F : pix(bx, by-1, cols, seed, 3, c);
    for (int r = 0; r < 4; r++)
      l[r*8 +: 8] = (bx == 0) ? 8'h81 : pix(bx-1, by, cols, seed, r, 3);
    return {COL_W'(bx), COL_W'(by), t, l};
  endfunction

  // ---------------- driver tasks ----------------
  // Called at the negedge after the final acceptance (or after start for an
  // empty picture): done follows one cycle later, busy drops after it.
  task automatic check_done_seq();
    check("done_pre", {busy, done, nb_valid}, 3'b100);
    @(negedge clk);
    check("done_pulse", {busy, done, nb_valid}, 3'b110);
    @(negedge clk);
    check("done_end", {busy, done, nb_valid}, 3'b000);
  endtask

  task automatic run_picture(input int cols, input int rows, input int seed,
                             input bit stall, input int abort_at);
    logic [NB_W-1:0] exp;
    logic [NB_W-1:0] snap;
    int wc;
    int n;
    int k;
    n = cols * rows;
    for (int i = 0; i < n; i++)
      exp_q.push_back(model_nb(i % cols, i / cols, cols, seed));
    @(negedge clk);
    blk_cols = (COL_W+1)'(cols);
    blk_rows = (COL_W+1)'(rows);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (n == 0) begin
      check_done_seq();
      return;
    end
    for (int i = 0; i < n; i++) begin
      wc = 0;
      while (!nb_valid && wc < 50) begin @(negedge clk); wc++; end
      if (!nb_valid) begin
        check("nb_valid_timeout", 0, 1);
        exp_q.delete();
        return;
      end
      if (stall) begin
        snap = {nb_x, nb_y, top, left};
        rec_valid = 1'b1;
        rec_data  = {4{32'hDEADBEEF}};
        k = $urandom_range(1, 5);
        if (i == 0) k = 5;
        repeat (k) begin
          @(negedge clk);
          check("stall_hold", {nb_valid, rec_ready, nb_x, nb_y, top, left}, {2'b10, snap});
        end
        rec_valid = 1'b0;
      end
      check("excl_pred", rec_ready, 0);
      exp = exp_q.pop_front();
      check($sformatf("nb_blk%0d", i), {nb_x, nb_y, top, left}, exp);
      nb_ready = 1'b1;
      @(negedge clk);
      nb_ready = 1'b0;
      wc = 0;
      while (!rec_ready && wc < 50) begin @(negedge clk); wc++; end
      if (!rec_ready) begin
        check("rec_ready_timeout", 0, 1);
        exp_q.delete();
        return;
      end
      check("excl_rec", nb_valid, 0);
      if (i == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("abort_reset", {busy, done, nb_valid, rec_ready, nb_x, nb_y, top, left}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        return;
      end
      if (stall) begin
        k = $urandom_range(1, 4);
        repeat (k) begin
          @(negedge clk);
          check("rec_stall", {rec_ready, nb_valid}, 2'b10);
        end
      end
      rec_data  = model_blk(i % cols, i / cols, cols, seed);
      rec_valid = 1'b1;
      @(negedge clk);
      rec_valid = 1'b0;
      rec_data  = '0;
    end
    check("queue_empty", exp_q.size(), 0);
    check_done_seq();
  endtask

  // ---------------- main sequence ----------------
  int base;

  initial begin
    rst_n = 1'b0; start = 1'b0; blk_cols = '0; blk_rows = '0;
    nb_ready = 1'b0; rec_valid = 1'b0; rec_data = '0;
    repeat (3) @(negedge clk);
    check("reset_state", {busy, done, nb_valid, rec_ready, nb_x, nb_y, top, left}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_state", {busy, done, nb_valid, rec_ready, nb_x, nb_y, top, left}, 0);

    run_picture(0, 3, 0, 1'b0, -1);     // empty picture
    run_picture(3, 0, 0, 1'b0, -1);     // empty picture, zero rows
    run_picture(1, 1, 0, 1'b0, -1);     // single block: defaults only
    run_picture(2, 2, 0, 1'b0, -1);     // 16*blk+4*r+c pattern
    run_picture(2, 2, 0, 1'b1, -1);     // backpressure on both sides
    run_picture(1, 3, 7, 1'b0, -1);     // one-column picture
    run_picture(64, 2, 11, 1'b0, -1);   // full-width row wrap

    base = done_cnt;
    run_picture(3, 2, 23, 1'b0, 3);     // reset during REC of block 3
    repeat (5) @(negedge clk);
    check("abort_no_done", done_cnt - base, 0);
    check("abort_idle", {busy, nb_valid, rec_ready}, 0);
    run_picture(3, 2, 31, 1'b0, -1);    // restart after abort

    run_picture(3, 3, $urandom_range(0, 255), 1'b1, -1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
